// File: rtl/gpioemu_master_if.sv
// ---------------------------------------------------------------------------
// gpioemu_master_if
//
// Purpose: bundles the command/response handshake and the peripheral bus of
// gpioemu_master into one interface.
//
// Signals:
//   cmd_valid, cmd_ready, cmd_a1[23:0], cmd_a2[23:0]  - command handshake
//   rsp_valid, rsp_ready, rsp_w[31:0], rsp_l[23:0],
//   rsp_err                                            - response handshake
//   saddress[15:0], srd, swr, sdata_out[31:0],
//   sdata_in[31:0]                                     - peripheral bus
//
// Modports:
//   master - the gpioemu_master side (drives the bus, accepts commands)
//   slave  - the environment side (issues commands, models the peripheral)
// ---------------------------------------------------------------------------
interface gpioemu_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [23:0] cmd_a1;
    logic [23:0] cmd_a2;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_w;
    logic [23:0] rsp_l;
    logic        rsp_err;

    logic [15:0] saddress;
    logic        srd;
    logic        swr;
    logic [31:0] sdata_out;
    logic [31:0] sdata_in;

    modport master (
        input  cmd_valid, cmd_a1, cmd_a2, rsp_ready, sdata_in,
        output cmd_ready, rsp_valid, rsp_w, rsp_l, rsp_err,
               saddress, srd, swr, sdata_out
    );

    modport slave (
        output cmd_valid, cmd_a1, cmd_a2, rsp_ready, sdata_in,
        input  cmd_ready, rsp_valid, rsp_w, rsp_l, rsp_err,
               saddress, srd, swr, sdata_out
    );
endinterface

// File: rtl/gpioemu_master.sv
// ---------------------------------------------------------------------------
// gpioemu_master
//
// Purpose: drives a memory-mapped multiply/popcount peripheral. For each
// accepted command it writes both operands, writes the start register,
// polls the status register until both status bits are set, reads the
// product and the ones count and returns them on the response handshake.
//
// Every bus access is SETUP (1 cycle) + STROBE (STROBE_LEN cycles) +
// HOLD (1 cycle). Read data is sampled on the edge that ends HOLD.
//
// Parameters:
//   STROBE_LEN - cycles each srd/swr strobe stays high (1..15)
//   POLL_GAP   - idle cycles between consecutive status polls (0..255)
//   TIMEOUT    - maximum status polls per operation (timeout build only)
//
// Ports:
//   clk     - single clock, all outputs change on its rising edge
//   n_reset - asynchronous active-low reset
//   bus     - gpioemu_master_if.master (command, response, peripheral bus)
//
// Optional feature: define GPIOEMU_MASTER_TIMEOUT_EN to bound the number
// of status polls; on expiry the response returns with rsp_err=1 and zero
// data. Without it the block polls forever and rsp_err is tied low.
// ---------------------------------------------------------------------------
module gpioemu_master #(
    parameter int unsigned STROBE_LEN = 2,
    parameter int unsigned POLL_GAP   = 4,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              n_reset,
    gpioemu_master_if.master  bus
);

    localparam logic [15:0] ADDR_A1   = 16'h037F;
    localparam logic [15:0] ADDR_A2   = 16'h0388;
    localparam logic [15:0] ADDR_CTRL = 16'h03A0;
    localparam logic [15:0] ADDR_W    = 16'h0390;
    localparam logic [15:0] ADDR_L    = 16'h0398;

    localparam logic [3:0] STROBE_LAST = 4'(STROBE_LEN);
    localparam logic [7:0] GAP_LAST    = 8'(POLL_GAP - 1);

    if (STROBE_LEN < 1 || STROBE_LEN > 15 || POLL_GAP > 255 || TIMEOUT < 1) begin : g_param_check
        $error("gpioemu_master: parameter out of range");
    end

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_A1,
        S_WR_A2,
        S_WR_GO,
        S_POLL,
        S_GAP,
        S_RD_W,
        S_RD_L,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_STROBE,
        PH_HOLD
    } phase_t;

    state_t      state_q,      state_d;
    phase_t      phase_q,      phase_d;
    logic [3:0]  strobe_cnt_q, strobe_cnt_d;
    logic [7:0]  gap_cnt_q,    gap_cnt_d;
    logic [23:0] a2_q,         a2_d;
    logic [15:0] saddress_q,   saddress_d;
    logic [31:0] sdata_out_q,  sdata_out_d;
    logic        srd_q,        srd_d;
    logic        swr_q,        swr_d;
    logic        cmd_ready_q,  cmd_ready_d;
    logic        rsp_valid_q,  rsp_valid_d;
    logic [31:0] rsp_w_q,      rsp_w_d;
    logic [23:0] rsp_l_q,      rsp_l_d;

`ifdef GPIOEMU_MASTER_TIMEOUT_EN
    localparam int unsigned POLL_W = $clog2(TIMEOUT + 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(TIMEOUT - 1);

    logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d;
    logic              rsp_err_q,  rsp_err_d;
`endif

    logic in_access;
    logic is_read;
    logic access_done;

    // States that own a bus access; the phase sequencer only runs in these.
    assign in_access = (state_q == S_WR_A1) || (state_q == S_WR_A2) ||
                       (state_q == S_WR_GO) || (state_q == S_POLL)  ||
                       (state_q == S_RD_W)  || (state_q == S_RD_L);
    assign is_read   = (state_q == S_POLL) || (state_q == S_RD_W) || (state_q == S_RD_L);

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        strobe_cnt_d = strobe_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        a2_d         = a2_q;
        saddress_d   = saddress_q;
        sdata_out_d  = sdata_out_q;
        srd_d        = 1'b0;
        swr_d        = 1'b0;
        rsp_valid_d  = rsp_valid_q;
        rsp_w_d      = rsp_w_q;
        rsp_l_d      = rsp_l_q;
        access_done  = 1'b0;
`ifdef GPIOEMU_MASTER_TIMEOUT_EN
        poll_cnt_d   = poll_cnt_q;
        rsp_err_d    = rsp_err_q;
`endif

        // Phase sequencer shared by every access. Strobes are only driven
        // high from here, so srd and swr can never be high together.
        if (in_access) begin
            unique case (phase_q)
                PH_SETUP: begin
                    phase_d      = PH_STROBE;
                    strobe_cnt_d = 4'd1;
                    srd_d        = is_read;
                    swr_d        = !is_read;
                end
                PH_STROBE: begin
                    if (strobe_cnt_q == STROBE_LAST) begin
                        phase_d      = PH_HOLD;
                        strobe_cnt_d = 4'd0;
                    end else begin
                        strobe_cnt_d = strobe_cnt_q + 4'd1;
                        srd_d        = is_read;
                        swr_d        = !is_read;
                    end
                end
                PH_HOLD: begin
                    access_done = 1'b1;
                    phase_d     = PH_SETUP;
                end
                default: phase_d = PH_SETUP;
            endcase
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    a2_d        = bus.cmd_a2;
                    state_d     = S_WR_A1;
                    phase_d     = PH_SETUP;
                    saddress_d  = ADDR_A1;
                    sdata_out_d = {8'h00, bus.cmd_a1};
`ifdef GPIOEMU_MASTER_TIMEOUT_EN
                    poll_cnt_d  = '0;
                    rsp_err_d   = 1'b0;
`endif
                end
            end
            S_WR_A1: begin
                if (access_done) begin
                    state_d     = S_WR_A2;
                    saddress_d  = ADDR_A2;
                    sdata_out_d = {8'h00, a2_q};
                end
            end
            S_WR_A2: begin
                if (access_done) begin
                    state_d     = S_WR_GO;
                    saddress_d  = ADDR_CTRL;
                    sdata_out_d = 32'h0;
                end
            end
            S_WR_GO: begin
                if (access_done) begin
                    state_d    = S_POLL;
                    saddress_d = ADDR_CTRL;
                end
            end
            S_POLL: begin
                if (access_done) begin
                    if (bus.sdata_in[1:0] == 2'b11) begin
                        state_d    = S_RD_W;
                        saddress_d = ADDR_W;
                    end
`ifdef GPIOEMU_MASTER_TIMEOUT_EN
                    // The poll just completed was the last one allowed.
                    else if (poll_cnt_q == POLL_LAST) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_w_d     = 32'h0;
                        rsp_l_d     = 24'h0;
                    end
`endif
                    else begin
`ifdef GPIOEMU_MASTER_TIMEOUT_EN
                        poll_cnt_d = poll_cnt_q + 1'b1;
`endif
                        // With no gap the next poll SETUP follows HOLD directly.
                        if (POLL_GAP == 0) begin
                            state_d = S_POLL;
                        end else begin
                            state_d   = S_GAP;
                            gap_cnt_d = 8'd0;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_POLL;
                    phase_d = PH_SETUP;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            S_RD_W: begin
                if (access_done) begin
                    rsp_w_d    = bus.sdata_in;
                    state_d    = S_RD_L;
                    saddress_d = ADDR_L;
                end
            end
            S_RD_L: begin
                if (access_done) begin
                    rsp_l_d     = bus.sdata_in[23:0];
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Registered so it stays low during reset and rises on the first
        // edge after release.
        cmd_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q      <= S_IDLE;
            phase_q      <= PH_SETUP;
            strobe_cnt_q <= 4'd0;
            gap_cnt_q    <= 8'd0;
            a2_q         <= 24'h0;
            saddress_q   <= 16'h0;
            sdata_out_q  <= 32'h0;
            srd_q        <= 1'b0;
            swr_q        <= 1'b0;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_w_q      <= 32'h0;
            rsp_l_q      <= 24'h0;
`ifdef GPIOEMU_MASTER_TIMEOUT_EN
            poll_cnt_q   <= '0;
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            strobe_cnt_q <= strobe_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            a2_q         <= a2_d;
            saddress_q   <= saddress_d;
            sdata_out_q  <= sdata_out_d;
            srd_q        <= srd_d;
            swr_q        <= swr_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_w_q      <= rsp_w_d;
            rsp_l_q      <= rsp_l_d;
`ifdef GPIOEMU_MASTER_TIMEOUT_EN
            poll_cnt_q   <= poll_cnt_d;
            rsp_err_q    <= rsp_err_d;
`endif
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_w     = rsp_w_q;
    assign bus.rsp_l     = rsp_l_q;
    assign bus.saddress  = saddress_q;
    assign bus.sdata_out = sdata_out_q;
    assign bus.srd       = srd_q;
    assign bus.swr       = swr_q;
`ifdef GPIOEMU_MASTER_TIMEOUT_EN
    assign bus.rsp_err   = rsp_err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_gpioemu_master.sv
// ---------------------------------------------------------------------------
// tb_gpioemu_master
//
// Purpose: directed self-checking bench for gpioemu_master built with
// STROBE_LEN=3, POLL_GAP=4, TIMEOUT=8. A small peripheral model answers the
// bus (product, ones count, status that stays busy for a chosen number of
// polls) and logs every access so the bus sequence can be checked.
// The timeout scenario runs only when GPIOEMU_MASTER_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_gpioemu_master;

    localparam int STROBE_LEN = 3;
    localparam int POLL_GAP   = 4;
    localparam int TIMEOUT    = 8;

    logic clk = 1'b0;
    logic n_reset;

    gpioemu_master_if bus ();

    gpioemu_master #(
        .STROBE_LEN (STROBE_LEN),
        .POLL_GAP   (POLL_GAP),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Peripheral model state, written only by the monitor process below.
    int          poll_total  = 0;
    int          rd_w_cnt    = 0;
    int          rd_l_cnt    = 0;
    int          wr_a1_cnt   = 0;
    int          wr_a2_cnt   = 0;
    int          go_cnt      = 0;
    int          width_bad   = 0;
    int          gap_bad     = 0;
    int          overlap_cnt = 0;
    logic [31:0] last_a1_word = 32'h0;
    logic [31:0] last_a2_word = 32'h0;
    logic [31:0] last_go_word = 32'hFFFF_FFFF;
    logic [31:0] prod         = 32'h0;
    int          ones         = 0;
    logic        srd_prev     = 1'b0;
    logic        swr_prev     = 1'b0;
    int          run_len      = 0;
    int          low_run      = 0;
    bit          last_was_poll = 1'b0;

    // Written only by the stimulus process.
    int poll_base  = 0;
    int busy_polls = 0;
    int base_polls, base_rdw, base_rdl, base_a1, base_a2, base_go;
    int base_width, base_gap, base_overlap;

    // Status reports busy (01) for busy_polls polls of this operation, then done (11).
    always_comb begin
        bus.sdata_in = 32'h0;
        case (bus.saddress)
            16'h03A0: bus.sdata_in = ((poll_total - poll_base) > busy_polls) ? 32'h3 : 32'h1;
            16'h0390: bus.sdata_in = prod;
            16'h0398: bus.sdata_in = {8'hA5, 24'(ones)};
            default:  bus.sdata_in = 32'h0;
        endcase
    end

    // Bus monitor: logs accesses, strobe widths and low gaps between polls.
    always begin
        logic [47:0] full;
        @(posedge clk);
        #1;
        if (bus.srd && bus.swr) overlap_cnt++;
        if ((bus.srd || bus.swr) && !(srd_prev || swr_prev)) begin
            if (bus.srd && bus.saddress == 16'h03A0) begin
                // Low stretch between polls is HOLD + POLL_GAP + SETUP.
                if (last_was_poll && low_run != POLL_GAP + 2) gap_bad++;
                poll_total++;
            end
            if (bus.srd && bus.saddress == 16'h0390) rd_w_cnt++;
            if (bus.srd && bus.saddress == 16'h0398) rd_l_cnt++;
            if (bus.swr && bus.saddress == 16'h037F) begin
                wr_a1_cnt++;
                last_a1_word = bus.sdata_out;
            end
            if (bus.swr && bus.saddress == 16'h0388) begin
                wr_a2_cnt++;
                last_a2_word = bus.sdata_out;
            end
            if (bus.swr && bus.saddress == 16'h03A0) begin
                go_cnt++;
                last_go_word = bus.sdata_out;
                full = {24'h0, last_a1_word[23:0]} * {24'h0, last_a2_word[23:0]};
                prod = full[31:0];
                ones = $countones(full[31:0]);
            end
            last_was_poll = bus.srd && (bus.saddress == 16'h03A0);
            run_len = 1;
        end else if (bus.srd || bus.swr) begin
            run_len++;
        end else if (srd_prev || swr_prev) begin
            if (run_len != STROBE_LEN) width_bad++;
            low_run = 1;
        end else begin
            low_run++;
        end
        srd_prev = bus.srd;
        swr_prev = bus.swr;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Issues one command and returns 1 time unit after the accepting edge.
    task automatic applyStimulus(input logic [23:0] a1, input logic [23:0] a2, input int busy);
        int n = 0;
        @(negedge clk);
        base_polls   = poll_total;
        base_rdw     = rd_w_cnt;
        base_rdl     = rd_l_cnt;
        base_a1      = wr_a1_cnt;
        base_a2      = wr_a2_cnt;
        base_go      = go_cnt;
        base_width   = width_bad;
        base_gap     = gap_bad;
        base_overlap = overlap_cnt;
        poll_base    = poll_total;
        busy_polls   = busy;
        bus.cmd_a1    = a1;
        bus.cmd_a2    = a2;
        bus.cmd_valid = 1'b1;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("cmd_accept", 64'(bus.cmd_ready), 64'h1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic waitResp();
        int n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rsp_arrives", 64'(bus.rsp_valid), 64'h1);
    endtask

    task automatic finishResp();
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rsp_valid_drop", 64'(bus.rsp_valid), 64'h0);
        checkOutput("ready_after_rsp", 64'(bus.cmd_ready), 64'h1);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic checkLog(input logic [23:0] a1, input logic [23:0] a2, input int polls, input int reads);
        checkOutput("wr_a1_count", 64'(wr_a1_cnt - base_a1), 64'd1);
        checkOutput("wr_a1_data",  64'(last_a1_word), {40'h0, 8'h00, a1});
        checkOutput("wr_a2_count", 64'(wr_a2_cnt - base_a2), 64'd1);
        checkOutput("wr_a2_data",  64'(last_a2_word), {40'h0, 8'h00, a2});
        checkOutput("go_count",    64'(go_cnt - base_go), 64'd1);
        checkOutput("go_data",     64'(last_go_word), 64'h0);
        checkOutput("poll_count",  64'(poll_total - base_polls), 64'(polls));
        checkOutput("rd_w_count",  64'(rd_w_cnt - base_rdw), 64'(reads));
        checkOutput("rd_l_count",  64'(rd_l_cnt - base_rdl), 64'(reads));
        checkOutput("strobe_width_errors", 64'(width_bad - base_width), 64'h0);
        checkOutput("poll_gap_errors",     64'(gap_bad - base_gap), 64'h0);
        checkOutput("strobe_overlap",      64'(overlap_cnt - base_overlap), 64'h0);
    endtask

    initial begin
        int n;
        int a1_before;
        bus.cmd_valid = 1'b0;
        bus.cmd_a1    = 24'h0;
        bus.cmd_a2    = 24'h0;
        bus.rsp_ready = 1'b0;
        n_reset       = 1'b1;

        // Reset values
        #1 n_reset = 1'b0;
        #2;
        checkOutput("rst_srd",       64'(bus.srd), 64'h0);
        checkOutput("rst_swr",       64'(bus.swr), 64'h0);
        checkOutput("rst_saddress",  64'(bus.saddress), 64'h0);
        checkOutput("rst_sdata_out", 64'(bus.sdata_out), 64'h0);
        checkOutput("rst_cmd_ready", 64'(bus.cmd_ready), 64'h0);
        checkOutput("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        checkOutput("rst_rsp_w",     64'(bus.rsp_w), 64'h0);
        checkOutput("rst_rsp_l",     64'(bus.rsp_l), 64'h0);
        checkOutput("rst_rsp_err",   64'(bus.rsp_err), 64'h0);
        repeat (2) @(negedge clk);
        checkOutput("rst_held_ready", 64'(bus.cmd_ready), 64'h0);
        n_reset = 1'b1;
        #1;
        checkOutput("ready_before_edge", 64'(bus.cmd_ready), 64'h0);
        @(posedge clk);
        #1;
        checkOutput("ready_after_release", 64'(bus.cmd_ready), 64'h1);

        // Op 1: 3*5, five busy polls, then response stalled for 10 cycles
        $display("[TB] op a1=3 a2=5");
        applyStimulus(24'd3, 24'd5, 5);
        checkOutput("setup_addr",  64'(bus.saddress), 64'h037F);
        checkOutput("setup_data",  64'(bus.sdata_out), 64'h3);
        checkOutput("setup_swr",   64'(bus.swr), 64'h0);
        checkOutput("setup_srd",   64'(bus.srd), 64'h0);
        checkOutput("busy_ready",  64'(bus.cmd_ready), 64'h0);
        @(posedge clk);
        #1;
        checkOutput("strobe_swr",  64'(bus.swr), 64'h1);
        checkOutput("strobe_srd",  64'(bus.srd), 64'h0);
        waitResp();
        checkOutput("op1_rsp_w",   64'(bus.rsp_w), 64'h0000_000F);
        checkOutput("op1_rsp_l",   64'(bus.rsp_l), 64'd4);
        checkOutput("op1_rsp_err", 64'(bus.rsp_err), 64'h0);
        checkLog(24'd3, 24'd5, 6, 1);
        a1_before = wr_a1_cnt;
        for (int i = 0; i < 10; i++) begin
            checkOutput("stall_valid", 64'(bus.rsp_valid), 64'h1);
            checkOutput("stall_w",     64'(bus.rsp_w), 64'h0000_000F);
            checkOutput("stall_l",     64'(bus.rsp_l), 64'd4);
            checkOutput("stall_err",   64'(bus.rsp_err), 64'h0);
            checkOutput("stall_ready", 64'(bus.cmd_ready), 64'h0);
            bus.cmd_valid = (i % 2 == 0);
            bus.cmd_a1    = 24'h123456;
            bus.cmd_a2    = 24'h000002;
            @(negedge clk);
        end
        finishResp();
        repeat (5) @(negedge clk);
        checkOutput("no_queued_cmd", 64'(wr_a1_cnt - a1_before), 64'h0);
        checkOutput("idle_ready",    64'(bus.cmd_ready), 64'h1);
        checkOutput("idle_addr_hold", 64'(bus.saddress), 64'h0398);
        checkOutput("idle_srd",      64'(bus.srd), 64'h0);

        // Op 2: max operands, status ready at first poll, rsp_ready held high early
        $display("[TB] op a1=FFFFFF a2=FFFFFF");
        bus.rsp_ready = 1'b1;
        applyStimulus(24'hFFFFFF, 24'hFFFFFF, 0);
        waitResp();
        checkOutput("op2_rsp_w",   64'(bus.rsp_w), 64'hFE00_0001);
        checkOutput("op2_rsp_l",   64'(bus.rsp_l), 64'd8);
        checkOutput("op2_rsp_err", 64'(bus.rsp_err), 64'h0);
        @(posedge clk);
        #1;
        checkOutput("op2_valid_drop", 64'(bus.rsp_valid), 64'h0);
        checkOutput("op2_ready",      64'(bus.cmd_ready), 64'h1);
        bus.rsp_ready = 1'b0;
        checkLog(24'hFFFFFF, 24'hFFFFFF, 1, 1);

        // Reset in the middle of the WR_A2 strobe
        $display("[TB] reset during WR_A2 strobe");
        applyStimulus(24'd1, 24'd2, 0);
        n = 0;
        while (!(bus.swr === 1'b1 && bus.saddress === 16'h0388) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reached_wr_a2", 64'(bus.swr), 64'h1);
        #2 n_reset = 1'b0;
        #1;
        checkOutput("midrst_swr",       64'(bus.swr), 64'h0);
        checkOutput("midrst_srd",       64'(bus.srd), 64'h0);
        checkOutput("midrst_saddress",  64'(bus.saddress), 64'h0);
        checkOutput("midrst_sdata_out", 64'(bus.sdata_out), 64'h0);
        checkOutput("midrst_cmd_ready", 64'(bus.cmd_ready), 64'h0);
        checkOutput("midrst_rsp_w",     64'(bus.rsp_w), 64'h0);
        checkOutput("midrst_rsp_l",     64'(bus.rsp_l), 64'h0);
        checkOutput("midrst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        @(negedge clk);
        n_reset = 1'b1;
        #1;
        checkOutput("midrst_ready_before", 64'(bus.cmd_ready), 64'h0);
        @(posedge clk);
        #1;
        checkOutput("midrst_ready_after", 64'(bus.cmd_ready), 64'h1);

        $display("[TB] op a1=7 a2=9 after reset");
        applyStimulus(24'd7, 24'd9, 2);
        waitResp();
        checkOutput("op3_rsp_w",   64'(bus.rsp_w), 64'h0000_003F);
        checkOutput("op3_rsp_l",   64'(bus.rsp_l), 64'd6);
        checkOutput("op3_rsp_err", 64'(bus.rsp_err), 64'h0);
        checkLog(24'd7, 24'd9, 3, 1);
        finishResp();

`ifdef GPIOEMU_MASTER_TIMEOUT_EN
        // Status never completes: abort after TIMEOUT polls
        $display("[TB] timeout op");
        applyStimulus(24'd2, 24'd3, 1000);
        waitResp();
        checkOutput("to_rsp_err", 64'(bus.rsp_err), 64'h1);
        checkOutput("to_rsp_w",   64'(bus.rsp_w), 64'h0);
        checkOutput("to_rsp_l",   64'(bus.rsp_l), 64'h0);
        checkLog(24'd2, 24'd3, TIMEOUT, 0);
        finishResp();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
